// File: rtl/multi_edge_detector_if.sv
// -----------------------------------------------------------------------------
// multi_edge_detector_if
// Bundles the data-side signals of multi_edge_detector so that a driver and the
// detector can be connected with a single port.
//
// Signals (directions as seen by the detector, i.e. the slave modport):
//   a_i            in   N_CH        raw, possibly asynchronous input levels
//   mode_i         in   2           event select: 00 none, 01 rise, 10 fall, 11 both
//   clr_i          in   1           one-cycle clear of sticky flags and counters
//   level_o        out  N_CH        filtered level per channel
//   rising_edge_o  out  N_CH        one-cycle pulse on an accepted 0->1 change
//   falling_edge_o out  N_CH        one-cycle pulse on an accepted 1->0 change
//   event_o        out  N_CH        one-cycle pulse on the edges chosen by mode_i
//   sticky_o       out  N_CH        per-channel event flag, held until clr_i
//   count_o        out  N_CH*CNT_W  per-channel saturating event counters
// -----------------------------------------------------------------------------
interface multi_edge_detector_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) ();
    logic [N_CH-1:0]       a_i;
    logic [1:0]            mode_i;
    logic                  clr_i;
    logic [N_CH-1:0]       level_o;
    logic [N_CH-1:0]       rising_edge_o;
    logic [N_CH-1:0]       falling_edge_o;
    logic [N_CH-1:0]       event_o;
    logic [N_CH-1:0]       sticky_o;
    logic [N_CH*CNT_W-1:0] count_o;

    // Driver side: produces inputs, observes status.
    modport master (
        output a_i, mode_i, clr_i,
        input  level_o, rising_edge_o, falling_edge_o, event_o, sticky_o, count_o
    );

    // Detector side.
    modport slave (
        input  a_i, mode_i, clr_i,
        output level_o, rising_edge_o, falling_edge_o, event_o, sticky_o, count_o
    );
endinterface

// File: rtl/multi_edge_detector.sv
// -----------------------------------------------------------------------------
// multi_edge_detector
// Per channel: SYNC_STAGES-deep synchroniser, glitch filter that needs
// FILTER_LEN consecutive differing samples before accepting a new level,
// registered rising/falling edge detect, mode-selected event pulse, sticky
// flag and saturating event counter.
//
// Ports:
//   clk    in   single clock, everything on posedge
//   reset  in   synchronous, active-high reset
//   bus    slave modport of multi_edge_detector_if (a_i, mode_i, clr_i in;
//          level_o, rising_edge_o, falling_edge_o, event_o, sticky_o,
//          count_o out). Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module multi_edge_detector #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    multi_edge_detector_if.slave bus
);

    localparam int                FW       = $clog2(FILTER_LEN) + 1;
    localparam logic [FW-1:0]     FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N_CH-1:0][FW-1:0]          flt_cnt_q, flt_cnt_d;
    logic [N_CH-1:0]                  level_q, level_d;
    logic [N_CH-1:0]                  level_prev_q;
    logic [N_CH-1:0]                  rise_q, rise_d;
    logic [N_CH-1:0]                  fall_q, fall_d;
    logic [N_CH-1:0]                  event_q, event_d;
    logic [N_CH-1:0]                  sticky_q, sticky_d;
    logic [N_CH-1:0][CNT_W-1:0]       count_q, count_d;
    logic [N_CH-1:0]                  sample_s;

    // Next-state logic for all channels: synchroniser shift, filter, edges, status.
    always_comb begin
        sync_d    = sync_q;
        flt_cnt_d = flt_cnt_q;
        level_d   = level_q;
        rise_d    = '0;
        fall_d    = '0;
        event_d   = '0;
        sticky_d  = sticky_q;
        count_d   = count_q;
        sample_s  = '0;
        for (int k = 0; k < N_CH; k++) begin
            // Newest sample enters bit 0; the oldest (bit SYNC_STAGES-1) drops out
            // of the truncating cast and is the synchronised value used below.
            sync_d[k]   = SYNC_STAGES'({sync_q[k], bus.a_i[k]});
            sample_s[k] = sync_q[k][SYNC_STAGES-1];

            // The counter holds how many consecutive samples have disagreed with
            // the current level; FILTER_LEN disagreements in a row flip it.
            if (sample_s[k] == level_q[k]) begin
                flt_cnt_d[k] = '0;
            end else if (flt_cnt_q[k] == FLT_LAST) begin
                level_d[k]   = sample_s[k];
                flt_cnt_d[k] = '0;
            end else begin
                flt_cnt_d[k] = flt_cnt_q[k] + FW'(1);
            end

            rise_d[k]  = level_q[k] & ~level_prev_q[k];
            fall_d[k]  = ~level_q[k] & level_prev_q[k];
            // mode_i is sampled together with the edge, so a later mode change
            // never re-qualifies an edge that was already reported.
            event_d[k] = (rise_d[k] & bus.mode_i[0]) | (fall_d[k] & bus.mode_i[1]);

            // A pending event beats a simultaneous clear: the channel restarts at 1.
            if (event_q[k]) begin
                sticky_d[k] = 1'b1;
                if (bus.clr_i) begin
                    count_d[k] = CNT_W'(1);
                end else begin
                    count_d[k] = sat_inc(count_q[k]);
                end
            end else if (bus.clr_i) begin
                sticky_d[k] = 1'b0;
                count_d[k]  = '0;
            end else begin
                sticky_d[k] = sticky_q[k];
                count_d[k]  = count_q[k];
            end
        end
    end

    // State registers with synchronous reset; previous level is cleared too so
    // no edge can appear in the reset or release cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            flt_cnt_q    <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            event_q      <= '0;
            sticky_q     <= '0;
            count_q      <= '0;
        end else begin
            sync_q       <= sync_d;
            flt_cnt_q    <= flt_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            event_q      <= event_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
        end
    end

    assign bus.level_o        = level_q;
    assign bus.rising_edge_o  = rise_q;
    assign bus.falling_edge_o = fall_q;
    assign bus.event_o        = event_q;
    assign bus.sticky_o       = sticky_q;
    assign bus.count_o        = count_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_edge_detector_if #(.N_CH(4), .CNT_W(8)) bus0 ();
    multi_edge_detector_if #(.N_CH(4), .CNT_W(2)) bus1 ();

    multi_edge_detector dut0 (.clk(clk), .reset(rst), .bus(bus0));
    multi_edge_detector #(.N_CH(4), .SYNC_STAGES(3), .FILTER_LEN(1), .CNT_W(2))
        dut1 (.clk(clk), .reset(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = default instance, 1 = (SYNC 3, FILTER 1, CNT_W 2).
    bit [3:0]  m_sh     [2][4];
    bit [15:0] m_hist   [2][4];
    int        m_nv     [2][4];
    bit        m_lvl    [2][4];
    bit        m_prise  [2][4];
    bit        m_pfall  [2][4];
    bit        m_rise   [2][4];
    bit        m_fall   [2][4];
    bit        m_ev     [2][4];
    bit        m_sticky [2][4];
    int        m_cnt    [2][4];

    int rise_n[4];
    int fall_n[4];
    int ev_n[4];

    typedef struct {
        logic       r;
        logic [3:0] a;
        logic [1:0] md;
        logic       c;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] ev;
        logic [3:0] stk;
        logic [7:0] cnt0;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of the behavioural model: the level follows the synchronised
    // input once its last FILTER_LEN samples all disagree with it; edge pulses
    // appear one cycle after the level change, status one cycle after that.
    task automatic model_step(input int m, input bit r, input bit [3:0] a,
                              input bit [1:0] md, input bit c);
        int  ns, nf, mx;
        bit  s, flip;
        ns = (m == 0) ? 2 : 3;
        nf = (m == 0) ? 3 : 1;
        mx = (m == 0) ? 255 : 3;
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                m_sh[m][k] = 4'd0; m_hist[m][k] = 16'd0; m_nv[m][k] = 0;
                m_lvl[m][k] = 1'b0; m_prise[m][k] = 1'b0; m_pfall[m][k] = 1'b0;
                m_rise[m][k] = 1'b0; m_fall[m][k] = 1'b0; m_ev[m][k] = 1'b0;
                m_sticky[m][k] = 1'b0; m_cnt[m][k] = 0;
            end else begin
                if (m_ev[m][k]) begin
                    m_sticky[m][k] = 1'b1;
                    m_cnt[m][k] = c ? 1 : ((m_cnt[m][k] < mx) ? m_cnt[m][k] + 1 : mx);
                end else if (c) begin
                    m_sticky[m][k] = 1'b0;
                    m_cnt[m][k] = 0;
                end
                m_rise[m][k] = m_prise[m][k];
                m_fall[m][k] = m_pfall[m][k];
                m_ev[m][k]   = (m_prise[m][k] & md[0]) | (m_pfall[m][k] & md[1]);
                s = m_sh[m][k][ns-1];
                m_sh[m][k] = {m_sh[m][k][2:0], a[k]};
                m_hist[m][k] = {m_hist[m][k][14:0], s};
                if (m_nv[m][k] < 16) m_nv[m][k]++;
                flip = (m_nv[m][k] >= nf);
                for (int i = 0; i < nf; i++)
                    if (m_hist[m][k][i] == m_lvl[m][k]) flip = 1'b0;
                if (flip) begin
                    m_lvl[m][k]   = ~m_lvl[m][k];
                    m_nv[m][k]    = 0;
                    m_prise[m][k] = m_lvl[m][k];
                    m_pfall[m][k] = ~m_lvl[m][k];
                end else begin
                    m_prise[m][k] = 1'b0;
                    m_pfall[m][k] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [3:0]  el [2];
        logic [3:0]  er [2];
        logic [3:0]  ef [2];
        logic [3:0]  ee [2];
        logic [3:0]  es [2];
        logic [31:0] ec0;
        logic [7:0]  ec1;
        ec0 = '0; ec1 = '0;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 4; k++) begin
                el[m][k] = m_lvl[m][k]; er[m][k] = m_rise[m][k]; ef[m][k] = m_fall[m][k];
                ee[m][k] = m_ev[m][k];  es[m][k] = m_sticky[m][k];
            end
        end
        for (int k = 0; k < 4; k++) begin
            ec0[k*8 +: 8] = 8'(m_cnt[0][k]);
            ec1[k*2 +: 2] = 2'(m_cnt[1][k]);
        end
        chk("m0_level",  {28'd0, bus0.level_o},        {28'd0, el[0]});
        chk("m0_rise",   {28'd0, bus0.rising_edge_o},  {28'd0, er[0]});
        chk("m0_fall",   {28'd0, bus0.falling_edge_o}, {28'd0, ef[0]});
        chk("m0_event",  {28'd0, bus0.event_o},        {28'd0, ee[0]});
        chk("m0_sticky", {28'd0, bus0.sticky_o},       {28'd0, es[0]});
        chk("m0_count",  bus0.count_o,                 ec0);
        chk("m1_level",  {28'd0, bus1.level_o},        {28'd0, el[1]});
        chk("m1_rise",   {28'd0, bus1.rising_edge_o},  {28'd0, er[1]});
        chk("m1_fall",   {28'd0, bus1.falling_edge_o}, {28'd0, ef[1]});
        chk("m1_event",  {28'd0, bus1.event_o},        {28'd0, ee[1]});
        chk("m1_sticky", {28'd0, bus1.sticky_o},       {28'd0, es[1]});
        chk("m1_count",  {24'd0, bus1.count_o},        {24'd0, ec1});
    endtask

    // Drive one cycle of inputs (from the falling edge), step the model,
    // then sample and compare on the following falling edge.
    task automatic cycle(input logic r, input logic [3:0] a, input logic [1:0] md, input logic c);
        rst = r;
        bus0.a_i = a; bus0.mode_i = md; bus0.clr_i = c;
        bus1.a_i = a; bus1.mode_i = md; bus1.clr_i = c;
        model_step(0, r, a, md, c);
        model_step(1, r, a, md, c);
        @(posedge clk);
        @(negedge clk);
        compare_model();
        for (int k = 0; k < 4; k++) begin
            rise_n[k] += int'(bus0.rising_edge_o[k]);
            fall_n[k] += int'(bus0.falling_edge_o[k]);
            ev_n[k]   += int'(bus0.event_o[k]);
        end
    endtask

    task automatic repeat_cycle(input int n, input logic [3:0] a, input logic [1:0] md);
        for (int i = 0; i < n; i++) cycle(1'b0, a, md, 1'b0);
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] a, input logic [3:0] lvl,
                                input logic [3:0] rise, input logic [3:0] fall,
                                input logic [3:0] ev, input logic [3:0] stk, input logic [7:0] cnt0);
        vec_t v;
        v.r = r; v.a = a; v.md = 2'b11; v.c = 1'b0;
        v.lvl = lvl; v.rise = rise; v.fall = fall; v.ev = ev; v.stk = stk; v.cnt0 = cnt0;
        return v;
    endfunction

    initial begin : main
        logic [3:0] ra;
        logic [1:0] rmd;
        logic       rc, rr;
        int         r1, f1, found, first;

        rst = 1'b1;
        bus0.a_i = 4'd0; bus0.mode_i = 2'b11; bus0.clr_i = 1'b0;
        bus1.a_i = 4'd0; bus1.mode_i = 2'b11; bus1.clr_i = 1'b0;
        for (int k = 0; k < 4; k++) begin rise_n[k] = 0; fall_n[k] = 0; ev_n[k] = 0; end
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 4; k++) begin
                m_sh[m][k] = 4'd0; m_hist[m][k] = 16'd0; m_nv[m][k] = 0; m_lvl[m][k] = 1'b0;
                m_prise[m][k] = 1'b0; m_pfall[m][k] = 1'b0; m_rise[m][k] = 1'b0;
                m_fall[m][k] = 1'b0; m_ev[m][k] = 1'b0; m_sticky[m][k] = 1'b0; m_cnt[m][k] = 0;
            end
        @(negedge clk);

        // Basic rise then fall on ch0, mode 11; a_i sampled at row 2 (T) and row 9 (T').
        tbl[0]  = mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        tbl[1]  = mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        tbl[2]  = mk(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        tbl[3]  = mk(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        tbl[4]  = mk(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        tbl[5]  = mk(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        tbl[6]  = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        tbl[7]  = mk(1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 8'd0);
        tbl[8]  = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'd1);
        tbl[9]  = mk(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'd1);
        tbl[10] = mk(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'd1);
        tbl[11] = mk(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'd1);
        tbl[12] = mk(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 8'd1);
        tbl[13] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 8'd1);
        tbl[14] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 8'd1);
        tbl[15] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 8'd2);
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].r, tbl[i].a, tbl[i].md, tbl[i].c);
            chk($sformatf("tbl%0d_level", i),  {28'd0, bus0.level_o},        {28'd0, tbl[i].lvl});
            chk($sformatf("tbl%0d_rise", i),   {28'd0, bus0.rising_edge_o},  {28'd0, tbl[i].rise});
            chk($sformatf("tbl%0d_fall", i),   {28'd0, bus0.falling_edge_o}, {28'd0, tbl[i].fall});
            chk($sformatf("tbl%0d_event", i),  {28'd0, bus0.event_o},        {28'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_sticky", i), {28'd0, bus0.sticky_o},       {28'd0, tbl[i].stk});
            chk($sformatf("tbl%0d_cnt0", i),   {24'd0, bus0.count_o[7:0]},   {24'd0, tbl[i].cnt0});
        end

        // Glitch rejection on ch1: 2-cycle pulse ignored, 3-cycle pulse accepted.
        r1 = rise_n[1]; f1 = fall_n[1];
        repeat_cycle(2, 4'b0010, 2'b11);
        repeat_cycle(10, 4'b0000, 2'b11);
        chk("glitch2_rise", rise_n[1], r1);
        chk("glitch2_fall", fall_n[1], f1);
        chk("glitch2_cnt1", {24'd0, bus0.count_o[15:8]}, 32'd0);
        repeat_cycle(3, 4'b0010, 2'b11);
        repeat_cycle(12, 4'b0000, 2'b11);
        chk("pulse3_rise", rise_n[1], r1 + 1);
        chk("pulse3_fall", fall_n[1], f1 + 1);

        // Mode 10 on ch2: only the fall is an event.
        cycle(1'b0, 4'b0000, 2'b10, 1'b1);
        r1 = rise_n[2]; f1 = fall_n[2]; found = ev_n[2];
        repeat_cycle(10, 4'b0100, 2'b10);
        repeat_cycle(12, 4'b0000, 2'b10);
        chk("mode10_rise", rise_n[2], r1 + 1);
        chk("mode10_fall", fall_n[2], f1 + 1);
        chk("mode10_events", ev_n[2], found + 1);
        chk("mode10_cnt2", {24'd0, bus0.count_o[23:16]}, 32'd1);

        // Saturation on the 2-bit-counter instance, ch3, mode 01.
        cycle(1'b0, 4'b0000, 2'b01, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            repeat_cycle(6, 4'b1000, 2'b01);
            repeat_cycle(6, 4'b0000, 2'b01);
            chk($sformatf("sat_edge%0d", i), {30'd0, bus1.count_o[7:6]}, (i < 3) ? i : 3);
        end

        // Clear colliding with an event on ch0 (count 4), ch1 idle at count 2.
        cycle(1'b0, 4'b0000, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            repeat_cycle(6, (i < 2) ? 4'b0011 : 4'b0001, 2'b01);
            repeat_cycle(6, 4'b0000, 2'b01);
        end
        chk("coll_pre_cnt0", {24'd0, bus0.count_o[7:0]}, 32'd4);
        chk("coll_pre_cnt1", {24'd0, bus0.count_o[15:8]}, 32'd2);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 4'b0001, 2'b01, 1'b0);
            if (bus0.event_o[0]) begin
                found = 1;
                break;
            end
        end
        chk("coll_event_seen", found, 1);
        cycle(1'b0, 4'b0001, 2'b01, 1'b1);
        chk("coll_cnt0", {24'd0, bus0.count_o[7:0]}, 32'd1);
        chk("coll_sticky0", {31'd0, bus0.sticky_o[0]}, 32'd1);
        chk("coll_cnt1", {24'd0, bus0.count_o[15:8]}, 32'd0);
        chk("coll_sticky1", {31'd0, bus0.sticky_o[1]}, 32'd0);

        // Reset in the middle of a filter count on ch0.
        repeat_cycle(10, 4'b0000, 2'b01);
        repeat_cycle(3, 4'b0001, 2'b01);
        cycle(1'b1, 4'b0001, 2'b01, 1'b0);
        chk("rst_all_level", {28'd0, bus0.level_o}, 32'd0);
        chk("rst_all_rise", {28'd0, bus0.rising_edge_o}, 32'd0);
        chk("rst_all_sticky", {28'd0, bus0.sticky_o}, 32'd0);
        chk("rst_all_count", bus0.count_o, 32'd0);
        first = 0;
        for (int n = 1; n <= 12; n++) begin
            cycle(1'b0, 4'b0001, 2'b01, 1'b0);
            if (bus0.rising_edge_o[0] && first == 0) first = n;
        end
        chk("rst_release_latency", first, 6);

        // Randomised traffic; the model compares every output each cycle.
        ra = 4'd0; rmd = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 3) == 0) ra[k] = ~ra[k];
            if ($urandom_range(0, 49) == 0) rmd = 2'($urandom_range(0, 3));
            rc = ($urandom_range(0, 31) == 0);
            rr = ($urandom_range(0, 499) == 0);
            cycle(rr, ra, rmd, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-bit edge detector.
- Each channel of asynchronous input is synchronised, glitch-filtered, then edge-detected.
- Per-channel events are selected by a mode, latched into sticky flags and counted in saturating counters.
- Sits between raw external/slow-domain inputs and control logic that needs clean one-cycle event pulses and polled status.

Parameters:
- N_CH, 4, number of independent input channels.
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel (legal range 1..4).
- FILTER_LEN, 3, consecutive stable synchronised samples required before a level change is accepted (1 = no filtering; legal range 1..16).
- CNT_W, 8, width of each per-channel event counter.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- a_i  input  N_CH  raw input levels; may be asynchronous to clk.
- mode_i  input  2  event select, applies to all channels: 00 none, 01 rising, 10 falling, 11 both.
- clr_i  input  1  one-cycle clear of all sticky flags and counters.
- level_o  output  N_CH  filtered level per channel.
- rising_edge_o  output  N_CH  one-cycle pulse on an accepted 0->1 transition; independent of mode_i.
- falling_edge_o  output  N_CH  one-cycle pulse on an accepted 1->0 transition; independent of mode_i.
- event_o  output  N_CH  one-cycle pulse on the edges selected by mode_i.
- sticky_o  output  N_CH  set by event_o, held until clr_i.
- count_o  output  N_CH*CNT_W  per-channel saturating event counts; channel k occupies bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset: every synchroniser stage, level_o, filter counters, rising_edge_o, falling_edge_o, event_o, sticky_o and count_o go to 0 on the first posedge with reset=1, and stay 0 while reset is held.
- Mid-operation reset aborts any filter count in progress. No edge pulse is generated in the cycle reset is asserted, or in the cycle it is released.
- Synchroniser: s[k] is a_i[k] delayed through SYNC_STAGES registers.
- Filter, per channel, with a counter of width clog2(FILTER_LEN)+1:
  - If s == level, the counter clears to 0.
  - If s != level and counter == FILTER_LEN-1, level <= s and the counter clears to 0.
  - Otherwise the counter increments.
- Glitch rule: a synchronised pulse shorter than FILTER_LEN cycles never changes level_o.
- Edge detect: registered, with previous level held internally.
  - rising_edge_o = level & ~level_prev.
  - falling_edge_o = ~level & level_prev.
  - Each pulse is exactly 1 cycle wide; rising and falling never coincide on one channel.
- Latency: a_i step sampled at posedge T gives level_o change at posedge T+SYNC_STAGES+FILTER_LEN-1, and the edge pulse high for the cycle following posedge T+SYNC_STAGES+FILTER_LEN. With defaults, the pulse comes 5 cycles after sampling.
- Start-up: after reset, an input held at 1 is reported as one rising edge once the filter accepts it.
- event_o: rising_edge_o gated by mode_i[0], OR falling_edge_o gated by mode_i[1], registered with the edges (same cycle). A mode_i change affects only edges detected after the change; it is never retroactive.
- sticky_o[k] and counters:
  - sticky_o[k] <= 1 on event_o[k].
  - count[k] <= count[k]+1 on event_o[k], saturating at 2^CNT_W-1 with no wrap.
- Clear: clr_i clears all sticky flags and counters the next cycle.
- clr_i and event_o[k] in the same cycle: the event wins, giving sticky=1 and count=1 for channel k. Other channels clear normally.
- Channels are fully independent; simultaneous edges on several channels are all reported in the same cycle.

Test Plan:
- Basic rising edge, defaults: reset 2 cycles; mode=11; a_i[0] 0->1 sampled at posedge T. Expect rising_edge_o[0]=1 for exactly one cycle after posedge T+5, event_o[0]=1 in the same cycle, sticky_o[0]=1, count ch0=1, other channels 0.
- Glitch rejection: a_i[1] high for 2 cycles, then low. Expect no change on level_o[1], no pulses, count ch1=0. A 3-cycle high pulse yields one rising edge and, later, one falling edge.
- Mode filtering: mode=10; a_i[2] toggles 0->1->0 with 10 cycles between transitions. Expect rising_edge_o and falling_edge_o each pulse once, event_o only on the fall, count ch2=1.
- Saturation (CNT_W=2): 5 rising edges on ch3 with mode=01. Expect count ch3 = 1,2,3,3,3.
- Clear collision: ch0 count=4; assert clr_i in the same cycle as an event on ch0 and with no event on ch1 (count 2). Expect ch0 count=1, sticky_o[0]=1, ch1 count=0, sticky_o[1]=0.
- Reset mid-filter: a_i[0] rises and reset is asserted 3 cycles later, for 1 cycle. Expect all outputs 0, no pulse in the reset or release cycle; after release with a_i[0] still 1, one rising pulse SYNC_STAGES+FILTER_LEN cycles later.
